// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature step decoder: direction levels,
// Gray-code states of {a, b}, transition classes and the direction lookup.
package quad_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Filtered channel pair encoded as {a_f, b_f}
    localparam logic [1:0] ST_00 = 2'b00;
    localparam logic [1:0] ST_10 = 2'b10;
    localparam logic [1:0] ST_11 = 2'b11;
    localparam logic [1:0] ST_01 = 2'b01;

    // Classification of one prev -> cur comparison
    typedef enum logic [1:0] {
        TR_NONE    = 2'b00,
        TR_STEP    = 2'b01,
        TR_ILLEGAL = 2'b10
    } trans_kind_e;

    // Returns {legal, dir}. legal = 1 only for a single-bit Gray move;
    // dir is meaningful only when legal = 1.
    function automatic logic [1:0] next_dir(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] res;
        res = {1'b0, DIR_UP};
        case ({prev, cur})
            {ST_00, ST_10}, {ST_10, ST_11}, {ST_11, ST_01}, {ST_01, ST_00}: res = {1'b1, DIR_UP};
            {ST_00, ST_01}, {ST_01, ST_11}, {ST_11, ST_10}, {ST_10, ST_00}: res = {1'b1, DIR_DN};
            default: res = {1'b0, DIR_UP};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// Encoder-side inputs and counter-side outputs of the step decoder.
interface quad_step_decoder_if;
    logic a_raw;
    logic b_raw;
    logic err_clr;
    logic en_o;
    logic up_down_o;
    logic err_o;
    logic err_sticky;

    // Environment side: drives the encoder lines and the error clear
    modport master (
        output a_raw, b_raw, err_clr,
        input  en_o, up_down_o, err_o, err_sticky
    );

    // Decoder side
    modport slave (
        input  a_raw, b_raw, err_clr,
        output en_o, up_down_o, err_o, err_sticky
    );
endinterface

// File: rtl/glitch_filter.sv
// Per-channel debounce: the output follows the input only after FILT_CNT
// consecutive samples disagree with the current output.
module glitch_filter #(
    parameter int FILT_CNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    localparam logic [3:0] LAST_CNT = 4'(FILT_CNT - 1);

    logic [3:0] cnt_r;
    logic       q_r;

    // Count disagreeing samples; any agreeing sample throws the pending change away
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 4'd0;
            q_r   <= 1'b0;
        end else if (d != q_r) begin
            if (cnt_r == LAST_CNT) begin
                q_r   <= d;
                cnt_r <= 4'd0;
            end else begin
                q_r   <= q_r;
                cnt_r <= cnt_r + 4'd1;
            end
        end else begin
            q_r   <= q_r;
            cnt_r <= 4'd0;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end for the 4-bit up/down counter: synchronises and
// debounces both channels, then turns Gray moves into one-cycle step pulses,
// a direction level and an illegal-transition flag.
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int FILT_CNT = 4,
    parameter bit X4       = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    quad_step_decoder_if.slave   bus
);

    logic [1:0]  sync_a_r;
    logic [1:0]  sync_b_r;
    logic        a_f_s;
    logic        b_f_s;
    logic [1:0]  cur_s;
    logic [1:0]  prev_r;
    logic [1:0]  dec_s;
    trans_kind_e kind_s;
    logic        en_s;
    logic        err_s;
    logic        dir_s;
    logic        en_r;
    logic        dir_r;
    logic        err_r;
    logic        sticky_r;

    // Two-flop synchronisers for the asynchronous encoder lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a_r <= 2'b00;
            sync_b_r <= 2'b00;
        end else begin
            sync_a_r <= {sync_a_r[0], bus.a_raw};
            sync_b_r <= {sync_b_r[0], bus.b_raw};
        end
    end

    glitch_filter #(.FILT_CNT(FILT_CNT)) u_filt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sync_a_r[1]),
        .q     (a_f_s)
    );

    glitch_filter #(.FILT_CNT(FILT_CNT)) u_filt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sync_b_r[1]),
        .q     (b_f_s)
    );

    assign cur_s = {a_f_s, b_f_s};
    assign dec_s = next_dir(prev_r, cur_s);

    // Classify the move and work out the next output values
    always_comb begin
        kind_s = TR_NONE;
        en_s   = 1'b0;
        err_s  = 1'b0;
        dir_s  = dir_r;
        if (cur_s == prev_r) begin
            kind_s = TR_NONE;
        end else if (dec_s[1]) begin
            kind_s = TR_STEP;
        end else begin
            kind_s = TR_ILLEGAL;
        end
        case (kind_s)
            TR_NONE: begin
                en_s = 1'b0;
            end
            TR_STEP: begin
                if (X4) begin
                    en_s  = 1'b1;
                    dir_s = dec_s[0];
                end else if ((prev_r == ST_00 && cur_s == ST_10) ||
                             (prev_r == ST_01 && cur_s == ST_11)) begin
                    // 1x mode counts only filtered A rising edges
                    en_s  = 1'b1;
                    dir_s = dec_s[0];
                end else begin
                    en_s = 1'b0;
                end
            end
            TR_ILLEGAL: begin
                err_s = 1'b1;
            end
            default: begin
                en_s  = 1'b0;
                err_s = 1'b0;
            end
        endcase
    end

    // Registered outputs; prev tracks the filtered pair every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r   <= ST_00;
            en_r     <= 1'b0;
            dir_r    <= DIR_UP;
            err_r    <= 1'b0;
            sticky_r <= 1'b0;
        end else begin
            prev_r <= cur_s;
            en_r   <= en_s;
            dir_r  <= dir_s;
            err_r  <= err_s;
            if (err_s) begin
                sticky_r <= 1'b1;
            end else if (bus.err_clr) begin
                sticky_r <= 1'b0;
            end else begin
                sticky_r <= sticky_r;
            end
        end
    end

    assign bus.en_o       = en_r;
    assign bus.up_down_o  = dir_r;
    assign bus.err_o      = err_r;
    assign bus.err_sticky = sticky_r;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: one 4x instance and one 1x instance,
// both FILT_CNT = 4, with a small counter4 model fed by the 4x pulses.
module tb_quad_step_decoder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // 4x instance pulse statistics and counter model
    int         p4, u4, d4, err4, cons4;
    logic       last_en4;
    logic [3:0] cnt4;
    int         steps4;
    logic       uf_first4;
    // 1x instance pulse statistics
    int         p1, u1, d1, err1, cons1;
    logic       last_en1;

    quad_step_decoder_if bus4 ();
    quad_step_decoder_if bus1 ();

    quad_step_decoder #(.FILT_CNT(4), .X4(1'b1)) dut_x4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    quad_step_decoder #(.FILT_CNT(4), .X4(1'b0)) dut_x1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        p4 = 0; u4 = 0; d4 = 0; err4 = 0; cons4 = 0;
        p1 = 0; u1 = 0; d1 = 0; err1 = 0; cons1 = 0;
    endtask

    // Advance n falling edges, sampling both instances at each one
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus4.en_o === 1'b1) begin
                p4++;
                if (bus4.up_down_o === 1'b1) u4++; else d4++;
                if (steps4 == 0) uf_first4 = (bus4.up_down_o === 1'b0) && (cnt4 == 4'd0);
                cnt4 = (bus4.up_down_o === 1'b1) ? cnt4 + 4'd1 : cnt4 - 4'd1;
                steps4++;
                if (last_en4 === 1'b1) cons4++;
            end
            last_en4 = bus4.en_o;
            if (bus4.err_o === 1'b1) err4++;
            if (bus1.en_o === 1'b1) begin
                p1++;
                if (bus1.up_down_o === 1'b1) u1++; else d1++;
                if (last_en1 === 1'b1) cons1++;
            end
            last_en1 = bus1.en_o;
            if (bus1.err_o === 1'b1) err1++;
        end
    endtask

    // Raw edge applied just before E0: en_o must rise only after E6
    task automatic expect_pulse4(input string tag, input logic dir);
        tick(6);
        check({tag, "_early"}, bus4.en_o, 1'b0);
        tick(1);
        check({tag, "_en"}, bus4.en_o, 1'b1);
        check({tag, "_dir"}, bus4.up_down_o, dir);
        tick(1);
        check({tag, "_one"}, bus4.en_o, 1'b0);
    endtask

    logic [1:0] fwd [4];
    logic [1:0] rev [4];

    initial begin
        checks = 0; errors = 0;
        last_en4 = 1'b0; last_en1 = 1'b0;
        cnt4 = 4'd0; steps4 = 0; uf_first4 = 1'b0;
        fwd[0] = 2'b10; fwd[1] = 2'b11; fwd[2] = 2'b01; fwd[3] = 2'b00;
        rev[0] = 2'b01; rev[1] = 2'b11; rev[2] = 2'b10; rev[3] = 2'b00;
        clear_stats();
        rst_n = 1'b0;
        bus4.a_raw = 1'b0; bus4.b_raw = 1'b0; bus4.err_clr = 1'b0;
        bus1.a_raw = 1'b0; bus1.b_raw = 1'b0; bus1.err_clr = 1'b0;
        tick(3);
        check("rst_en", bus4.en_o, 1'b0);
        check("rst_dir", bus4.up_down_o, 1'b1);
        check("rst_err", bus4.err_o, 1'b0);
        check("rst_sticky", bus4.err_sticky, 1'b0);
        check("rst_dir_x1", bus1.up_down_o, 1'b1);
        rst_n = 1'b1;

        // Idle
        clear_stats();
        tick(50);
        check("idle_pulses", p4 + p1, 0);
        check("idle_err", err4 + err1, 0);
        check("idle_dir", bus4.up_down_o, 1'b1);
        check("idle_sticky", bus4.err_sticky, 1'b0);

        // 4x forward cycle
        clear_stats();
        cnt4 = 4'd0; steps4 = 0;
        for (int i = 0; i < 4; i++) begin
            {bus4.a_raw, bus4.b_raw} = fwd[i];
            expect_pulse4("fwd", 1'b1);
            tick(12);
        end
        check("fwd_pulses", p4, 4);
        check("fwd_up", u4, 4);
        check("fwd_cnt", cnt4, 4'd4);
        check("fwd_consec", cons4, 0);
        check("fwd_err", err4, 0);

        // 4x reverse cycle: counter wraps from 0
        clear_stats();
        cnt4 = 4'd0; steps4 = 0; uf_first4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            {bus4.a_raw, bus4.b_raw} = rev[i];
            expect_pulse4("rev", 1'b0);
            tick(12);
        end
        check("rev_pulses", p4, 4);
        check("rev_dn", d4, 4);
        check("rev_cnt", cnt4, 4'd12);
        check("rev_uf_first", uf_first4, 1'b1);

        // 3-cycle glitch on A is swallowed
        clear_stats();
        bus4.a_raw = 1'b1;
        tick(3);
        bus4.a_raw = 1'b0;
        tick(20);
        check("glitch3_pulses", p4, 0);
        check("glitch3_err", err4, 0);

        // 4-cycle pulse on A passes: up then down
        clear_stats();
        bus4.a_raw = 1'b1;
        tick(4);
        bus4.a_raw = 1'b0;
        tick(20);
        check("glitch4_pulses", p4, 2);
        check("glitch4_up", u4, 1);
        check("glitch4_dn", d4, 1);
        check("glitch4_consec", cons4, 0);

        // Both channels flip together
        clear_stats();
        {bus4.a_raw, bus4.b_raw} = 2'b11;
        tick(20);
        check("flip_err", err4, 1);
        check("flip_en", p4, 0);
        check("flip_sticky", bus4.err_sticky, 1'b1);
        check("flip_dir_hold", bus4.up_down_o, 1'b0);

        // Second error coinciding with err_clr: set wins
        clear_stats();
        {bus4.a_raw, bus4.b_raw} = 2'b00;
        tick(6);
        bus4.err_clr = 1'b1;
        tick(1);
        bus4.err_clr = 1'b0;
        check("flip2_err", bus4.err_o, 1'b1);
        check("flip2_sticky", bus4.err_sticky, 1'b1);
        tick(5);
        check("flip2_en", p4, 0);
        bus4.err_clr = 1'b1;
        tick(1);
        bus4.err_clr = 1'b0;
        check("clr_sticky", bus4.err_sticky, 1'b0);

        // 1x mode: 3 forward cycles then 2 reverse cycles
        clear_stats();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 4; i++) begin
                {bus1.a_raw, bus1.b_raw} = fwd[i];
                tick(20);
            end
        end
        check("x1_fwd_up", u1, 3);
        check("x1_fwd_dn", d1, 0);
        check("x1_fwd_dir", bus1.up_down_o, 1'b1);
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 4; i++) begin
                {bus1.a_raw, bus1.b_raw} = rev[i];
                tick(20);
            end
        end
        check("x1_pulses", p1, 5);
        check("x1_rev_dn", d1, 2);
        check("x1_err", err1, 0);
        check("x1_consec", cons1, 0);

        // Reset while a down pulse is on the outputs
        {bus1.a_raw, bus1.b_raw} = 2'b01;
        tick(20);
        {bus1.a_raw, bus1.b_raw} = 2'b11;
        tick(7);
        check("mid_pre_en", bus1.en_o, 1'b1);
        check("mid_pre_dir", bus1.up_down_o, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_en", bus1.en_o, 1'b0);
        check("mid_rst_dir", bus1.up_down_o, 1'b1);
        check("mid_rst_err", bus1.err_o, 1'b0);
        {bus1.a_raw, bus1.b_raw} = 2'b00;
        tick(3);
        rst_n = 1'b1;
        clear_stats();
        tick(30);
        check("post_rst_pulses", p1 + p4, 0);
        check("post_rst_err", err1 + err4, 0);
        check("post_rst_dir", bus1.up_down_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
